sram_b_stream_fifo: RTL and testbench

- Streaming FIFO controller that owns a 1-write/1-read banked SRAM (8-bit words, 2^17 deep) and sits directly upstream of it.
- Converts valid/ready producer and consumer streams into SRAM port 0 writes and port 1 reads.
- Hides the 1-cycle SRAM read latency with a 2-entry output buffer, so throughput is 1 word/cycle each way.
- Guarantees no same-address read/write collision reaches the SRAM.

---
 rtl/sram_b_stream_fifo.sv | 120 ++++++++++++
 tb/tb_sram_b_stream_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_b_stream_fifo.sv
// Valid/ready FIFO controller in front of a 1W/1R SRAM; a 2-entry output buffer hides the
// 1-cycle read latency. Define SRAM_B_STREAM_FIFO_FLUSH_EN to add a synchronous FLUSH input.
module sram_b_stream_fifo #(
    parameter int ABITS = 17,
    parameter int DBITS = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
`ifdef SRAM_B_STREAM_FIFO_FLUSH_EN
    input  logic             FLUSH,
`endif
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [DBITS-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [DBITS-1:0] OUT_DATA,
    output logic [ABITS+1:0] COUNT,
    output logic             MEM_CE0,
    output logic [ABITS-1:0] MEM_A0,
    output logic [DBITS-1:0] MEM_D0,
    output logic             MEM_WE0,
    output logic [DBITS-1:0] MEM_WEM0,
    output logic             MEM_CE1,
    output logic [ABITS-1:0] MEM_A1,
    input  logic [DBITS-1:0] MEM_Q1
);

    localparam logic [ABITS:0]   DEPTH   = {1'b1, {ABITS{1'b0}}};
    localparam logic [ABITS-1:0] PTR_ONE = {{(ABITS-1){1'b0}}, 1'b1};

    logic [ABITS-1:0] wr_ptr;
    logic [ABITS-1:0] rd_ptr;
    logic [ABITS:0]   mem_cnt;
    logic             rd_inflight;
    logic [DBITS-1:0] obuf [2];
    logic [1:0]       buf_cnt;

    logic             flush;
    logic             push;
    logic             pop;
    logic             issue;
    logic [1:0]       occ_after_pop;
    logic             cap_pos;

`ifdef SRAM_B_STREAM_FIFO_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign IN_READY  = (mem_cnt != DEPTH) && !flush;
    assign push      = IN_VALID && IN_READY && RSTN;

    assign OUT_VALID = (buf_cnt != 2'd0);
    assign OUT_DATA  = obuf[0];
    assign pop       = OUT_VALID && OUT_READY && !flush;

    // A read is only issued when the buffer is sure to have a free slot when its data lands.
    assign occ_after_pop = buf_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    assign issue         = (mem_cnt != '0) && (occ_after_pop < 2'd2) && !flush && RSTN;

    assign cap_pos = ((buf_cnt == 2'd1) && !pop) || ((buf_cnt == 2'd2) && pop);

    assign MEM_CE0  = push;
    assign MEM_WE0  = push;
    assign MEM_A0   = wr_ptr;
    assign MEM_D0   = IN_DATA;
    assign MEM_WEM0 = {DBITS{push}};
    assign MEM_CE1  = issue;
    assign MEM_A1   = rd_ptr;

    assign COUNT = {1'b0, mem_cnt}
                 + {{(ABITS+1){1'b0}}, rd_inflight}
                 + {{ABITS{1'b0}}, buf_cnt};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            rd_inflight <= 1'b0;
            buf_cnt     <= 2'd0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            rd_inflight <= 1'b0;
            buf_cnt     <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            mem_cnt     <= mem_cnt + {{ABITS{1'b0}}, push} - {{ABITS{1'b0}}, issue};
            rd_inflight <= issue;
            buf_cnt     <= buf_cnt + {1'b0, rd_inflight} - {1'b0, pop};
        end
    end

    // Read data lands behind whatever survives this cycle's pop; a capture into slot 0 wins over the shift.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            obuf[0] <= '0;
            obuf[1] <= '0;
        end else if (!flush) begin
            if (rd_inflight && !cap_pos) begin
                obuf[0] <= MEM_Q1;
            end else if (pop) begin
                obuf[0] <= obuf[1];
            end
            if (rd_inflight && cap_pos) begin
                obuf[1] <= MEM_Q1;
            end
        end
    end

endmodule

// File: tb/tb_sram_b_stream_fifo.sv
// Bench for sram_b_stream_fifo (ABITS=4): latency table, directed full/wrap/reset sequences
// and random traffic, all scored against a queue model of the FIFO contents.
module tb_sram_b_stream_fifo;

    localparam int ABITS = 4;
    localparam int DBITS = 8;
    localparam int DEPTH = 1 << ABITS;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DBITS-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DBITS-1:0] out_data;
    logic [ABITS+1:0] count;
    logic             mem_ce0;
    logic [ABITS-1:0] mem_a0;
    logic [DBITS-1:0] mem_d0;
    logic             mem_we0;
    logic [DBITS-1:0] mem_wem0;
    logic             mem_ce1;
    logic [ABITS-1:0] mem_a1;
    logic [DBITS-1:0] mem_q1 = '0;

    int errors = 0;
    int checks = 0;

    sram_b_stream_fifo #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .CLK(clk),
        .RSTN(rstn),
`ifdef SRAM_B_STREAM_FIFO_FLUSH_EN
        .FLUSH(flush),
`endif
        .IN_VALID(in_valid),
        .IN_READY(in_ready),
        .IN_DATA(in_data),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .OUT_DATA(out_data),
        .COUNT(count),
        .MEM_CE0(mem_ce0),
        .MEM_A0(mem_a0),
        .MEM_D0(mem_d0),
        .MEM_WE0(mem_we0),
        .MEM_WEM0(mem_wem0),
        .MEM_CE1(mem_ce1),
        .MEM_A1(mem_a1),
        .MEM_Q1(mem_q1)
    );

    initial forever #5 clk = ~clk;

    // Behavioural 1W/1R SRAM with bit write mask and one cycle of read latency.
    logic [DBITS-1:0] sram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    always @(posedge clk) begin
        if (mem_ce0 && mem_we0)
            sram[mem_a0] <= (sram[mem_a0] & ~mem_wem0) | (mem_d0 & mem_wem0);
        if (mem_ce1)
            mem_q1 <= sram[mem_a1];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit iv, input logic [DBITS-1:0] id, input bit ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
    endtask

    // Reference model: the FIFO is just an ordered list of accepted words.
    logic [DBITS-1:0] model_q [$];
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                model_q.delete();
            end else begin
                checkOutput("read/write collision", int'(mem_ce0 && mem_ce1 && (mem_a0 == mem_a1)), 0);
                checkOutput("count vs model", int'(count), model_q.size());
                if (model_q.size() == 0)
                    checkOutput("valid while empty", int'(out_valid), 0);
                if (!flush && model_q.size() < DEPTH)
                    checkOutput("ready below depth", int'(in_ready), 1);
                if (flush) begin
                    model_q.delete();
                end else begin
                    if (out_valid && out_ready && model_q.size() != 0) begin
                        checkOutput("pop data order", int'(out_data), int'(model_q[0]));
                        void'(model_q.pop_front());
                    end
                    if (in_valid && in_ready)
                        model_q.push_back(in_data);
                end
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        rstn      = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        #1;
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset count", int'(count), 0);
        checkOutput("reset out_data", int'(out_data), 0);
        checkOutput("reset ce0", int'(mem_ce0), 0);
        checkOutput("reset we0", int'(mem_we0), 0);
        checkOutput("reset wem0", int'(mem_wem0), 0);
        checkOutput("reset ce1", int'(mem_ce1), 0);
        @(negedge clk);
        rstn     = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("ready after reset", int'(in_ready), 1);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (count == 0 && !out_valid) done = 1'b1;
        end
        checkOutput({tag, " drain finished"}, int'(done), 1);
        checkOutput({tag, " model empty"}, model_q.size(), 0);
    endtask

    // From an empty FIFO, a single push must surface exactly three cycles later.
    task automatic expectFirstWord(input string tag, input logic [DBITS-1:0] w);
        applyStimulus(1'b1, w, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput({tag, " not valid +1"}, int'(out_valid), 0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput({tag, " not valid +2"}, int'(out_valid), 0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput({tag, " valid +3"}, int'(out_valid), 1);
        checkOutput({tag, " first word"}, int'(out_data), int'(w));
    endtask

    typedef struct {
        bit             iv;
        bit [DBITS-1:0] id;
        bit             ordy;
        int             e_irdy;
        int             e_ov;
        int             e_od;
        int             e_cnt;
        int             e_ce0;
        int             e_ce1;
        int             e_a0;
        int             e_a1;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit iv, ordy;
        int pct_in, pct_out;

        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1, 0, 0,     0, 1, 0, 0, 0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1, 0, 0,     1, 0, 1, 0, 0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1, 0, 0,     1, 0, 0, 0, 0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1, 1, 'hA5,  1, 0, 0, 0, 0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1, 0, 0,     0, 0, 0, 0, 0};

        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy);
            checkOutput($sformatf("tbl[%0d] in_ready", i), int'(in_ready), vecs[i].e_irdy);
            checkOutput($sformatf("tbl[%0d] out_valid", i), int'(out_valid), vecs[i].e_ov);
            if (vecs[i].e_ov != 0)
                checkOutput($sformatf("tbl[%0d] out_data", i), int'(out_data), vecs[i].e_od);
            checkOutput($sformatf("tbl[%0d] count", i), int'(count), vecs[i].e_cnt);
            checkOutput($sformatf("tbl[%0d] ce0", i), int'(mem_ce0), vecs[i].e_ce0);
            checkOutput($sformatf("tbl[%0d] we0", i), int'(mem_we0), vecs[i].e_ce0);
            checkOutput($sformatf("tbl[%0d] ce1", i), int'(mem_ce1), vecs[i].e_ce1);
            if (vecs[i].e_ce0 != 0)
                checkOutput($sformatf("tbl[%0d] a0", i), int'(mem_a0), vecs[i].e_a0);
            if (vecs[i].e_ce1 != 0)
                checkOutput($sformatf("tbl[%0d] a1", i), int'(mem_a1), vecs[i].e_a1);
        end

        $display("[TB] continuous stream 0x00..0xFF");
        for (int c = 0; c < 259; c++) begin
            applyStimulus(c < 256, 8'(c), 1'b1);
            if (c >= 3) begin
                checkOutput("stream no bubble", int'(out_valid), 1);
                checkOutput("stream data", int'(out_data), (c - 3) & 'hFF);
            end
        end
        drain("stream");

        $display("[TB] full and wrap");
        doReset();
        for (int c = 0; c < DEPTH + 2; c++) begin
            applyStimulus(1'b1, 8'(c + 16), 1'b0);
            checkOutput("fill ready", int'(in_ready), 1);
        end
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("full ready low", int'(in_ready), 0);
        checkOutput("full count", int'(count), DEPTH + 2);
        checkOutput("full no write", int'(mem_ce0), 0);
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("full pop issues read", int'(mem_ce1), 1);
        checkOutput("full issue addr", int'(mem_a1), 2);
        checkOutput("full ready during pop", int'(in_ready), 0);
        applyStimulus(1'b1, 8'h66, 1'b0);
        checkOutput("ready after one pop", int'(in_ready), 1);
        checkOutput("count after one pop", int'(count), DEPTH + 1);
        applyStimulus(1'b1, 8'h77, 1'b1);
        checkOutput("refilled count", int'(count), DEPTH + 2);
        checkOutput("refilled ready low", int'(in_ready), 0);
        // The pop at DEPTH+2 is not matched by a push, so steady push+pop holds DEPTH+1 words.
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b1, 8'(c + 128), 1'b1);
            checkOutput("wrap ready", int'(in_ready), 1);
            checkOutput("wrap valid", int'(out_valid), 1);
            checkOutput("wrap count", int'(count), DEPTH + 1);
        end
        drain("wrap");

        $display("[TB] consumer stalls 1,0,0,1");
        for (int c = 0; c < 48; c++)
            applyStimulus(1'b1, 8'($urandom), (c % 4 == 0) || (c % 4 == 3));
        drain("stall");

        $display("[TB] reset mid-stream");
        for (int c = 0; c < 6; c++)
            applyStimulus(1'b1, 8'(c + 200), 1'b1);
        checkOutput("pre-reset valid", int'(out_valid), 1);
        doReset();
        expectFirstWord("post-reset", 8'h3C);
        drain("post-reset");

`ifdef SRAM_B_STREAM_FIFO_FLUSH_EN
        $display("[TB] flush mid-stream");
        for (int c = 0; c < 6; c++)
            applyStimulus(1'b1, 8'(c + 90), 1'b1);
        @(negedge clk);
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("flush ready low", int'(in_ready), 0);
        checkOutput("flush no write", int'(mem_ce0), 0);
        checkOutput("flush no read", int'(mem_ce1), 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("after flush valid", int'(out_valid), 0);
        checkOutput("after flush count", int'(count), 0);
        expectFirstWord("post-flush", 8'h3C);
        drain("post-flush");
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            pct_in  = (c < 750) ? 80 : 30;
            pct_out = (c < 750) ? 30 : 80;
            iv   = ($urandom_range(99) < pct_in);
            ordy = ($urandom_range(99) < pct_out);
            applyStimulus(iv, 8'($urandom), ordy);
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
